alu_seq: RTL and testbench

- Parametrised, registered successor to the team's 3-bit combinational ALU. Adds configurable operand width, new ops, a multi-cycle multiply, and a stored carry for chained adds.
- Operands enter through a valid/ready handshake; results and status flags leave registered through a second valid/ready handshake.
- Sits between the register-file read stage and the writeback/flag logic of the datapath.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_mul_shift_add.sv | 59 +++++
 rtl/alu_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states, flag bundle.
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_EQ   = 4'd5;
    localparam logic [3:0] OP_LT   = 4'd6;
    localparam logic [3:0] OP_GT   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_ADDC = 4'd12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef struct packed {
        logic carry;
        logic zero;
        logic eq;
        logic lt;
        logic gt;
    } flags_t;

    // Ops whose carry_out is remembered for a following ADDC.
    function automatic logic op_writes_carry(input logic [3:0] op);
        logic wr;
        case (op)
            OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_MUL, OP_ADDC: wr = 1'b1;
            default:                                         wr = 1'b0;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/alu_mul_shift_add.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
module alu_mul_shift_add #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_d;

    // done fires during the final iteration so the caller can register the product that same edge.
    always_comb begin
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
    end

    assign done    = (cnt_q == CW'(1));
    assign product = acc_d;

    // Operand capture on start, then one shift-add step per cycle while the counter runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_q    <= acc_d;
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q - CW'(1);
        end else begin
            acc_q    <= acc_q;
            mcand_q  <= mcand_q;
            mplier_q <= mplier_q;
            cnt_q    <= cnt_q;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides, multi-cycle MUL and a stored carry for ADDC.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SELW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SELW-1:0]  sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             equal,
    output logic             less_than,
    output logic             greater_than
);

    localparam int OPW = 4;
    localparam int SHW = $clog2(WIDTH);

    logic [1:0]          state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    result_q, result_d;
    flags_t              flags_q, flags_d;
    logic                carry_reg_q, carry_reg_d;

    logic [SELW+OPW-1:0] sel_ext_s;
    logic [3:0]          op_s;
    logic                accept_s;
    logic [WIDTH:0]      add_s, addc_s, sub_s, shl_s, shr_s;
    logic [SHW-1:0]      shamt_s;
    logic [WIDTH-1:0]    alu_res_s;
    flags_t              alu_fl_s;
    logic                mul_start_s, mul_done_s;
    logic [2*WIDTH-1:0]  mul_prod_s;
    logic                mul_carry_s;

    // Select codes beyond the 4-bit op space collapse to NOP.
    assign sel_ext_s = {{OPW{1'b0}}, sel};
    assign op_s      = (sel_ext_s[SELW+OPW-1:OPW] != '0) ? OP_NOP : sel_ext_s[OPW-1:0];

    assign in_ready  = !rst && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
    assign accept_s  = in_valid && in_ready;

    assign shamt_s = b[SHW-1:0];
    assign add_s   = {1'b0, a} + {1'b0, b};
    assign addc_s  = add_s + {{WIDTH{1'b0}}, carry_reg_q};
    assign sub_s   = {1'b0, a} - {1'b0, b};
    assign shl_s   = {1'b0, a} << shamt_s;
    assign shr_s   = {a, 1'b0} >> shamt_s;

    alu_mul_shift_add #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .a       (a),
        .b       (b),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    assign mul_carry_s = (mul_prod_s[2*WIDTH-1:WIDTH] != '0);

    // Single-cycle datapath; compare ops report only through their own flag.
    always_comb begin
        alu_res_s = '0;
        alu_fl_s  = '0;
        case (op_s)
            OP_ADD:  {alu_fl_s.carry, alu_res_s} = add_s;
            OP_SUB:  {alu_fl_s.carry, alu_res_s} = sub_s;
            OP_AND:  alu_res_s = a & b;
            OP_OR:   alu_res_s = a | b;
            OP_XOR:  alu_res_s = a ^ b;
            OP_EQ:   alu_fl_s.eq = (a == b);
            OP_LT:   alu_fl_s.lt = (a < b);
            OP_GT:   alu_fl_s.gt = (a > b);
            OP_SHL:  {alu_fl_s.carry, alu_res_s} = shl_s;
            OP_SHR:  {alu_res_s, alu_fl_s.carry} = shr_s;
            OP_ADDC: {alu_fl_s.carry, alu_res_s} = addc_s;
            default: alu_res_s = '0;
        endcase
        if ((op_s == OP_EQ) || (op_s == OP_LT) || (op_s == OP_GT)) begin
            alu_fl_s.zero = 1'b0;
        end else begin
            alu_fl_s.zero = (alu_res_s == '0) && !alu_fl_s.carry;
        end
    end

    // Control FSM: a retiring HOLD result and a newly accepted op share one edge.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        carry_reg_d = carry_reg_q;
        mul_start_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept_s && (op_s == OP_MUL)) begin
                    mul_start_s = 1'b1;
                    state_d     = ST_BUSY;
                    out_valid_d = 1'b0;
                end else if (accept_s) begin
                    state_d     = ST_HOLD;
                    out_valid_d = 1'b1;
                    result_d    = alu_res_s;
                    flags_d     = alu_fl_s;
                    if (op_writes_carry(op_s)) begin
                        carry_reg_d = alu_fl_s.carry;
                    end else begin
                        carry_reg_d = carry_reg_q;
                    end
                end else if ((state_q == ST_HOLD) && out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d     = state_q;
                end
            end
            ST_BUSY: begin
                if (mul_done_s) begin
                    state_d       = ST_HOLD;
                    out_valid_d   = 1'b1;
                    result_d      = mul_prod_s[WIDTH-1:0];
                    flags_d       = '0;
                    flags_d.carry = mul_carry_s;
                    flags_d.zero  = (mul_prod_s[WIDTH-1:0] == '0) && !mul_carry_s;
                    carry_reg_d   = mul_carry_s;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            carry_reg_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            carry_reg_q <= carry_reg_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign carry_out    = flags_q.carry;
    assign zero         = flags_q.zero;
    assign equal        = flags_q.eq;
    assign less_than    = flags_q.lt;
    assign greater_than = flags_q.gt;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases plus random ops against an arithmetic model.
module tb_alu_seq;

    localparam int W  = 8;
    localparam int SW = 4;
    localparam int M  = 1 << W;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready;
    logic carry_out, zero, equal, less_than, greater_than;
    logic [W-1:0]  a, b, result;
    logic [SW-1:0] sel;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .SELW(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out), .zero(zero), .equal(equal),
        .less_than(less_than), .greater_than(greater_than)
    );

    typedef struct {
        logic [W-1:0] res;
        logic c, z, e, l, g;
        int   due;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          pcnt = 0;
    int          model_creg = 0;
    logic        rand_rdy = 1'b0;
    logic        seen = 1'b0;
    logic [W+4:0] snap;

    always @(posedge clk) pcnt <= pcnt + 1;

    function automatic void check(string name, longint act, longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Reference: plain integer arithmetic on the op definitions.
    function automatic exp_t model(int op, int ai, int bi);
        exp_t e;
        int r = 0, c = 0, s, sh, p;
        bit cmp = 1'b0;
        e.e = 1'b0; e.l = 1'b0; e.g = 1'b0; e.due = 0;
        case (op)
            1:  begin s = ai + bi; r = s % M; c = (s >= M) ? 1 : 0; end
            2:  begin r = (ai - bi + M) % M; c = (ai < bi) ? 1 : 0; end
            3:  r = ai & bi;
            4:  r = ai | bi;
            5:  begin cmp = 1'b1; e.e = (ai == bi); end
            6:  begin cmp = 1'b1; e.l = (ai < bi); end
            7:  begin cmp = 1'b1; e.g = (ai > bi); end
            8:  r = ai ^ bi;
            9:  begin sh = bi % W; r = (ai << sh) % M; c = (sh > 0) ? ((ai >> (W - sh)) & 1) : 0; end
            10: begin sh = bi % W; r = ai >> sh; c = (sh > 0) ? ((ai >> (sh - 1)) & 1) : 0; end
            11: begin p = ai * bi; r = p % M; c = ((p / M) != 0) ? 1 : 0; end
            12: begin s = ai + bi + model_creg; r = s % M; c = (s >= M) ? 1 : 0; end
            default: r = 0;
        endcase
        e.res = r[W-1:0];
        e.c   = c[0];
        e.z   = cmp ? 1'b0 : ((r == 0) && (c == 0));
        if (op == 1 || op == 2 || op == 9 || op == 10 || op == 11 || op == 12) model_creg = c;
        return e;
    endfunction

    // Present one op, wait (bounded) for acceptance, queue its expected response.
    task automatic issue(input int op, input int aa, input int bb);
        bit   got = 1'b0;
        int   ac = 0;
        exp_t e;
        in_valid = 1'b1; sel = op[SW-1:0]; a = aa[W-1:0]; b = bb[W-1:0];
        for (int t = 0; t < 500 && !got; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got = 1'b1;
                ac  = pcnt;
            end
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        check("accept_timeout", got, 1);
        if (got) begin
            e = model(op, aa, bb);
            e.due = ac + ((op == 11) ? W + 1 : 1);
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: latency on first presentation, stability while held, values on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                snap = {result, carry_out, zero, equal, less_than, greater_than};
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got result %0d, expected no output", result);
                end else begin
                    check("latency", pcnt, sb[0].due);
                end
            end else begin
                check("hold_stable", {result, carry_out, zero, equal, less_than, greater_than}, snap);
            end
            if (out_ready) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("carry_out", carry_out, e.c);
                    check("zero", zero, e.z);
                    check("equal", equal, e.e);
                    check("less_than", less_than, e.l);
                    check("greater_than", greater_than, e.g);
                end
                seen = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_reset", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {out_valid, result, carry_out, zero, equal, less_than, greater_than}, 0);
        @(posedge clk);
        #1;

        issue(1, 200, 100);
        issue(2, 5, 5);
        issue(2, 3, 7);
        issue(1, 255, 1);
        issue(12, 0, 0);
        issue(11, 16, 20);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("busy_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("hold_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        issue(11, 3, 4);
        drain();

        out_ready = 1'b0;
        issue(5, 9, 9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        issue(1, 255, 1);
        drain();
        issue(11, 16, 20);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("in_ready_in_reset2", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        model_creg = 0;
        @(negedge clk);
        check("abort_outputs", {out_valid, result, carry_out, zero, equal, less_than, greater_than}, 0);
        @(posedge clk);
        #1;
        issue(12, 1, 1);

        issue(9, 8'h81, 1);
        issue(9, 8'h81, 0);
        issue(10, 8'h81, 7);
        issue(10, 8'h81, 8);
        issue(11, 255, 255);
        issue(2, 0, 255);
        issue(0, 5, 5);
        issue(15, 7, 7);
        issue(6, 3, 4);
        issue(7, 3, 4);
        issue(3, 8'hF0, 8'h3C);
        issue(4, 8'hF0, 8'h0C);
        issue(8, 8'hAA, 8'hAA);
        drain();

        rand_rdy = 1'b1;
        repeat (300) issue($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
